// File: rtl/decode_control_stage.sv
// Decode/control stage: turns an RV32I/M instruction word into a registered control bundle.
// Non-M instructions issue one cycle after acceptance; RV32M instructions are held for MULDIV_CYCLES first.
`timescale 1ns/1ps

module decode_control_stage #(
    parameter int ALU_OP_WIDTH  = 3,
    parameter int M_EXT         = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [31:0]             INSTR,
    input  logic                    OUT_READY,
    input  logic                    FLUSH,
    output logic                    OUT_VALID,
    output logic                    WRITE_ENABLE,
    output logic                    MEM_WRITE,
    output logic                    MEM_READ,
    output logic                    BRANCH,
    output logic                    JUMP,
    output logic                    PC_SELECT,
    output logic                    JAL_SELECT,
    output logic                    DATA_MEM_SELECT,
    output logic [ALU_OP_WIDTH-1:0] ALU_OP,
    output logic                    MULDIV,
    output logic                    ILLEGAL
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unusedOperandBits;

    assign opcode            = INSTR[6:0];
    assign rd                = INSTR[11:7];
    assign funct3            = INSTR[14:12];
    assign funct7            = INSTR[31:25];
    assign unusedOperandBits = ^INSTR[24:15];

    // Flag vector order: {WE, MW, MR, BRANCH, JUMP, PC_SEL, JAL_SEL, DMS}
    logic [7:0] decFlags;
    logic [2:0] decAlu;
    logic       decMuldiv;
    logic       decIllegal;

    always_comb begin
        decFlags   = 8'h00;
        decAlu     = 3'b000;
        decMuldiv  = 1'b0;
        decIllegal = 1'b0;
        case (opcode)
            OP_REG: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    decFlags = 8'b1000_0000;
                end else if (funct7 == 7'b0000001 && M_EXT != 0) begin
                    decFlags  = 8'b1000_0000;
                    decAlu    = 3'b110;
                    decMuldiv = 1'b1;
                end else begin
                    decIllegal = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    decIllegal = 1'b1;
                end else begin
                    decFlags = 8'b1010_0001;
                    decAlu   = 3'b001;
                end
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    decFlags = 8'b1000_1010;
                    decAlu   = 3'b010;
                end else begin
                    decIllegal = 1'b1;
                end
            end
            OP_IMM: begin
                // Only the shift-immediates constrain funct7
                if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
                    (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
                    decIllegal = 1'b1;
                end else begin
                    decFlags = 8'b1000_0000;
                    decAlu   = 3'b011;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
                    decFlags = 8'b0100_0000;
                    decAlu   = 3'b100;
                end else begin
                    decIllegal = 1'b1;
                end
            end
            OP_LUI: begin
                decFlags = 8'b1000_0000;
                decAlu   = 3'b101;
            end
            OP_AUIPC: begin
                decFlags = 8'b1000_0100;
                decAlu   = 3'b100;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    decIllegal = 1'b1;
                end else begin
                    decFlags = 8'b0001_0100;
                    decAlu   = 3'b100;
                end
            end
            OP_JAL: begin
                decFlags = 8'b1000_1110;
                decAlu   = 3'b100;
            end
            default: decIllegal = 1'b1;
        endcase
        if (rd == 5'd0) begin
            decFlags[7] = 1'b0;
        end
    end

    logic [1:0]              state_q,    state_d;
    logic [3:0]              cnt_q,      cnt_d;
    logic                    outValid_q, outValid_d;
    logic [7:0]              flags_q,    flags_d;
    logic [ALU_OP_WIDTH-1:0] aluOp_q,    aluOp_d;
    logic                    muldiv_q,   muldiv_d;
    logic                    illegal_q,  illegal_d;
    logic                    accept;

    assign IN_READY = RESETN && !FLUSH && (state_q == IDLE) && (!outValid_q || OUT_READY);
    assign accept   = IN_VALID && IN_READY;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        outValid_d = outValid_q;
        flags_d    = flags_q;
        aluOp_d    = aluOp_q;
        muldiv_d   = muldiv_q;
        illegal_d  = illegal_q;
        if (FLUSH) begin
            state_d    = IDLE;
            cnt_d      = 4'd0;
            outValid_d = 1'b0;
            flags_d    = 8'h00;
            aluOp_d    = '0;
            muldiv_d   = 1'b0;
            illegal_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        flags_d   = decFlags;
                        aluOp_d   = ALU_OP_WIDTH'(decAlu);
                        muldiv_d  = decMuldiv;
                        illegal_d = decIllegal;
                        if (decMuldiv) begin
                            outValid_d = 1'b0;
                            cnt_d      = CNT_LOAD;
                            state_d    = HOLD;
                        end else begin
                            outValid_d = 1'b1;
                        end
                    end else if (outValid_q && OUT_READY) begin
                        outValid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt_q == 4'd0) begin
                        state_d    = ISSUE;
                        outValid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ISSUE: begin
                    if (OUT_READY) begin
                        outValid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    outValid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            outValid_q <= 1'b0;
            flags_q    <= 8'h00;
            aluOp_q    <= '0;
            muldiv_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            outValid_q <= outValid_d;
            flags_q    <= flags_d;
            aluOp_q    <= aluOp_d;
            muldiv_q   <= muldiv_d;
            illegal_q  <= illegal_d;
        end
    end

    assign OUT_VALID       = outValid_q;
    assign WRITE_ENABLE    = flags_q[7];
    assign MEM_WRITE       = flags_q[6];
    assign MEM_READ        = flags_q[5];
    assign BRANCH          = flags_q[4];
    assign JUMP            = flags_q[3];
    assign PC_SELECT       = flags_q[2];
    assign JAL_SELECT      = flags_q[1];
    assign DATA_MEM_SELECT = flags_q[0];
    assign ALU_OP          = aluOp_q;
    assign MULDIV          = muldiv_q;
    assign ILLEGAL         = illegal_q;

endmodule

// File: tb/tb_decode_control_stage.sv
// Scoreboard bench for decode_control_stage: the driver predicts each accepted bundle and its
// issue cycle from the instruction-set rules; a negedge monitor compares whatever the DUT presents.
`timescale 1ns/1ps

module tb_decode_control_stage;

    localparam int ALU_OP_WIDTH  = 3;
    localparam int M_EXT         = 1;
    localparam int MULDIV_CYCLES = 4;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] INSTR = 32'h0;
    logic        OUT_READY = 1'b1;
    logic        FLUSH = 1'b0;
    logic        OUT_VALID;
    logic        WRITE_ENABLE, MEM_WRITE, MEM_READ, BRANCH;
    logic        JUMP, PC_SELECT, JAL_SELECT, DATA_MEM_SELECT;
    logic [ALU_OP_WIDTH-1:0] ALU_OP;
    logic        MULDIV, ILLEGAL;

    decode_control_stage #(
        .ALU_OP_WIDTH (ALU_OP_WIDTH),
        .M_EXT        (M_EXT),
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .IN_VALID       (IN_VALID),
        .IN_READY       (IN_READY),
        .INSTR          (INSTR),
        .OUT_READY      (OUT_READY),
        .FLUSH          (FLUSH),
        .OUT_VALID      (OUT_VALID),
        .WRITE_ENABLE   (WRITE_ENABLE),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_READ       (MEM_READ),
        .BRANCH         (BRANCH),
        .JUMP           (JUMP),
        .PC_SELECT      (PC_SELECT),
        .JAL_SELECT     (JAL_SELECT),
        .DATA_MEM_SELECT(DATA_MEM_SELECT),
        .ALU_OP         (ALU_OP),
        .MULDIV         (MULDIV),
        .ILLEGAL        (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // flags order: {WE, MW, MR, BRANCH, JUMP, PC_SEL, JAL_SEL, DMS}
    typedef struct packed {
        logic [7:0] flags;
        logic [2:0] alu;
        logic       muldiv;
        logic       illegal;
    } bundle_t;

    typedef struct {
        bundle_t b;
        int      visibleAt;
    } sbItem_t;

    sbItem_t sbQueue[$];
    bit      frontSeen = 1'b0;
    int      cycle = 0;
    int      tests = 0;
    int      failures = 0;

    always @(posedge CLK) cycle <= cycle + 1;

    function automatic bundle_t refDecode(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [7:0] fl;
        logic [2:0] alu;
        logic       mul;
        logic       ok;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        fl  = 8'h00;
        alu = 3'd0;
        mul = 1'b0;
        ok  = 1'b1;
        case (op)
            7'h33: begin
                fl = 8'h80;
                if (f7 == 7'h01 && M_EXT != 0) begin
                    alu = 3'd6;
                    mul = 1'b1;
                end else begin
                    ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                end
            end
            7'h03: begin fl = 8'hA1; alu = 3'd1; ok = (f3 != 3'd3) && (f3 < 3'd6); end
            7'h67: begin fl = 8'h8A; alu = 3'd2; ok = (f3 == 3'd0); end
            7'h13: begin
                fl = 8'h80;
                alu = 3'd3;
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            end
            7'h23: begin fl = 8'h40; alu = 3'd4; ok = (f3 < 3'd3); end
            7'h37: begin fl = 8'h80; alu = 3'd5; end
            7'h17: begin fl = 8'h84; alu = 3'd4; end
            7'h63: begin fl = 8'h14; alu = 3'd4; ok = (f3 != 3'd2) && (f3 != 3'd3); end
            7'h6F: begin fl = 8'h8E; alu = 3'd4; end
            default: ok = 1'b0;
        endcase
        if (!ok) return '{flags: 8'h00, alu: 3'd0, muldiv: 1'b0, illegal: 1'b1};
        if (ins[11:7] == 5'd0) fl[7] = 1'b0;
        return '{flags: fl, alu: alu, muldiv: mul, illegal: 1'b0};
    endfunction

    function automatic bundle_t dutBundle();
        return '{flags: {WRITE_ENABLE, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SELECT, JAL_SELECT, DATA_MEM_SELECT},
                 alu: ALU_OP[2:0], muldiv: MULDIV, illegal: ILLEGAL};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, predicts IN_READY and any acceptance, then advances past the edge.
    task automatic applyStimulus(input logic rstn, input logic flush, input logic inValid,
                                 input logic [31:0] instr, input logic outReady);
        logic    expReady;
        bundle_t exp;
        RESETN    = rstn;
        FLUSH     = flush;
        IN_VALID  = inValid;
        INSTR     = instr;
        OUT_READY = outReady;
        #1;
        expReady = rstn && !flush &&
                   (sbQueue.size() == 0 ||
                    (cycle >= sbQueue[0].visibleAt && outReady && !sbQueue[0].b.muldiv));
        checkOutput("in_ready", {31'd0, IN_READY}, {31'd0, expReady});
        if (inValid && expReady) begin
            exp = refDecode(instr);
            sbQueue.push_back('{b: exp, visibleAt: cycle + 1 + (exp.muldiv ? MULDIV_CYCLES : 0)});
        end
        @(posedge CLK);
        #1;
        if (!rstn || flush) begin
            sbQueue.delete();
            frontSeen = 1'b0;
            checkOutput(rstn ? "flush_valid" : "reset_valid", {31'd0, OUT_VALID}, 32'd0);
            checkOutput(rstn ? "flush_bundle" : "reset_bundle", 32'(dutBundle()), 32'd0);
        end
    endtask

    // Monitor: whatever the DUT presents must be the scoreboard front, on time and stable.
    always @(negedge CLK) begin
        if (OUT_VALID === 1'b1) begin
            if (sbQueue.size() == 0) begin
                tests++;
                failures++;
                $display("[TB] FAIL unexpected_valid at cycle %0d: got OUT_VALID 1, expected 0", cycle);
            end else begin
                if (!frontSeen) begin
                    checkOutput("issue_cycle", cycle, sbQueue[0].visibleAt);
                    frontSeen = 1'b1;
                end
                checkOutput("bundle", 32'(dutBundle()), 32'(sbQueue[0].b));
                if (OUT_READY) begin
                    void'(sbQueue.pop_front());
                    frontSeen = 1'b0;
                end
            end
        end else if (sbQueue.size() > 0 && cycle >= sbQueue[0].visibleAt) begin
            checkOutput("out_valid_due", {31'd0, OUT_VALID}, 32'd1);
            void'(sbQueue.pop_front());
            frontSeen = 1'b0;
        end
    end

    function automatic logic [31:0] randomInstr();
        logic [31:0] ins;
        logic [6:0]  ops [10];
        logic [6:0]  f7s [4];
        ops = '{7'h33, 7'h03, 7'h67, 7'h13, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h33};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        ins = $urandom;
        if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 4) != 0) ins[31:25] = f7s[$urandom_range(0, 3)];
        if ($urandom_range(0, 5) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    initial begin
        @(posedge CLK);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00A00093, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00A00093, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h02B50533, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 32'h00A00093, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00A00093, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000013, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00112023, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 32'h00012083, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00012083, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h02B54533, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h00A00093, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h02B54533, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h00A00093, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 59) != 0, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 9) < 7, randomInstr(), $urandom_range(0, 9) < 7);
        end

        for (int i = 0; i < MULDIV_CYCLES + 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("drained", sbQueue.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/decode_control_stage.md
DECODE_CONTROL_STAGE -- requirements
Module: decode_control_stage

Interface
REQ-001 SHALL have parameter ALU_OP_WIDTH, default 3, ALU_OP width in bits, legal range 3..8.
REQ-002 SHALL have parameter M_EXT, default 1, 1 enables RV32M decode, 0 makes funct7=0000001 R-type illegal.
REQ-003 SHALL have parameter MULDIV_CYCLES, default 4, hold cycles for an M-ext instruction, legal range 1..15.
REQ-004 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port RESETN  input  1  synchronous, active-low reset.
REQ-006 SHALL have port IN_VALID  input  1  INSTR valid from fetch.
REQ-007 SHALL have port IN_READY  output  1  stage accepts INSTR this cycle.
REQ-008 SHALL have port INSTR  input  32  raw RV32I/M instruction word.
REQ-009 SHALL have port OUT_READY  input  1  execute stage accepts outputs this cycle.
REQ-010 SHALL have port FLUSH  input  1  discard held and incoming instruction.
REQ-011 SHALL have port OUT_VALID  output  1  registered control bundle valid.
REQ-012 SHALL have ports WRITE_ENABLE, MEM_WRITE, MEM_READ, BRANCH  output  1 each  registered control flags.
REQ-013 SHALL have ports JUMP, PC_SELECT, JAL_SELECT, DATA_MEM_SELECT  output  1 each  registered control flags.
REQ-014 SHALL have port ALU_OP  output  ALU_OP_WIDTH  registered ALU class, zero-extended.
REQ-015 SHALL have port MULDIV  output  1  registered; instruction is RV32M.
REQ-016 SHALL have port ILLEGAL  output  1  registered; instruction undecodable.

Function
REQ-017 Decode table SHALL be: R-type WE, ALU 000; load (f3 000/001/010/100/101) WE MR DMS, ALU 001; JALR (f3 000) WE JUMP JAL_SEL, ALU 010.
REQ-018 Decode table SHALL continue: OP-IMM WE, ALU 011; store (f3 000/001/010) MW, ALU 100; LUI WE, ALU 101; AUIPC WE PC_SEL, ALU 100.
REQ-019 Decode table SHALL continue: branch (f3 000/001/100-111) BRANCH PC_SEL, ALU 100; JAL JUMP JAL_SEL PC_SEL WE, ALU 100; RV32M (M_EXT=1) WE MULDIV, ALU 110.
REQ-020 ILLEGAL SHALL be 1, all other flags 0, ALU_OP 0 for: unlisted opcode/f3; R-type f7 not 0000000, not 0100000 with f3 000/101, not 0000001 with M_EXT=1; SLLI f7!=0; SRLI/SRAI f7 not 0000000/0100000.
REQ-021 WRITE_ENABLE SHALL be forced 0 when INSTR[11:7]==0; other flags unaffected.
REQ-022 States SHALL be IDLE, HOLD, ISSUE; IN_READY = RESETN && !FLUSH && state==IDLE && (!OUT_VALID || OUT_READY), combinational.
REQ-023 Accept (IN_VALID && IN_READY) of non-MULDIV: bundle registered, OUT_VALID=1 next cycle, state stays IDLE; latency 1 cycle.
REQ-024 Accept of MULDIV instruction: bundle registered, OUT_VALID=0, counter loaded MULDIV_CYCLES-1, state HOLD.
REQ-025 HOLD: counter decrements each cycle; at counter==0 transition to ISSUE with OUT_VALID=1; MULDIV_CYCLES=1 gives HOLD for exactly one cycle.
REQ-026 ISSUE: OUT_VALID held with bundle stable until OUT_READY=1, then OUT_VALID=0, state IDLE; no accept in that cycle.
REQ-027 OUT_VALID=1 and OUT_READY=0 SHALL hold all outputs unchanged; OUT_VALID && OUT_READY && accept in same cycle SHALL load new bundle back-to-back.
REQ-028 OUT_VALID && OUT_READY without accept SHALL clear OUT_VALID next cycle; flags then don't-care.
REQ-029 FLUSH=1 SHALL, next cycle, give OUT_VALID=0, state IDLE, counter 0, all flags 0; incoming INSTR not accepted; FLUSH overrides HOLD/ISSUE and handshakes.

Reset
REQ-030 RESETN=0 at a rising edge SHALL set OUT_VALID, all flags, MULDIV, ILLEGAL, ALU_OP to 0, state IDLE, counter 0; overrides FLUSH and any operation in progress.
REQ-031 IN_READY SHALL be 0 while RESETN=0 and SHALL be 1 in first cycle after release.

Verification
REQ-032 INSTR 0x00A00093 (ADDI x1), OUT_READY=1 -> next cycle OUT_VALID=1, WE=1, ALU_OP=011, others 0.
REQ-033 INSTR 0x02B50533 (MUL), MULDIV_CYCLES=4 -> IN_READY=0 and OUT_VALID=0 for 4 cycles, then OUT_VALID=1, MULDIV=1, ALU_OP=110, WE=1.
REQ-034 INSTR 0x00000013 (ADDI x0) -> OUT_VALID=1, WE=0, ALU_OP=011; INSTR 0xFFFFFFFF -> ILLEGAL=1, flags 0.
REQ-035 SW 0x00112023 accepted, OUT_READY=0 for 3 cycles -> MW=1, ALU_OP=100 stable, IN_READY=0; OUT_READY=1 with LW 0x00012083 -> LW bundle next cycle.
REQ-036 FLUSH during HOLD of DIV 0x02B54533 -> next cycle OUT_VALID=0, IN_READY=1, no MULDIV issued; RESETN=0 mid-HOLD -> same, all outputs 0.
